// File: rtl/piso_shift_reg_if.sv
// Load handshake and serial lane of the parallel-in/serial-out shifter.
// master = word source / serial sink side, slave = the shifter itself.
interface piso_shift_reg_if #(
    parameter int WIDTH = 8
);
    // Handshake: a word moves on a rising edge where load_valid && load_ready.
    // The source holds load_valid and data_in stable until that edge.
    // load_valid seen while load_ready is low is ignored.
    logic             load_valid;
    logic [WIDTH-1:0] data_in;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             ser_valid;
    logic             last_bit;
    logic             done;

    modport master (
        output load_valid, data_in, shift_en,
        input  load_ready, serial_out, ser_valid, last_bit, done
    );

    modport slave (
        input  load_valid, data_in, shift_en,
        output load_ready, serial_out, ser_valid, last_bit, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with valid/ready load and
// ser_valid/last_bit framing; transmit partner of the left-shift capture register.
module piso_shift_reg #(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_shift_reg_if.slave    bus,
    output logic               state_dbg_o,
    output logic [CW-1:0]      cnt_dbg_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_w;
    logic             load_ready_w;
    logic [WIDTH-1:0] shifted_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Zero fill means the register is empty once the last bit has gone,
    // so serial_out reads 0 in IDLE without extra gating.
    assign shifted_w = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = last_w && bus.shift_en;
        // A load takes priority: in IDLE it swallows shift_en, and on the
        // final-bit edge it replaces the finished word back-to-back.
        if (bus.load_valid && load_ready_w) begin
            state_d = SHIFT;
            shreg_d = bus.data_in;
            cnt_d   = CW'(WIDTH);
        end else if (state_q == SHIFT && bus.shift_en) begin
            shreg_d = shifted_w;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        last_w         = (state_q == SHIFT) && (cnt_q == CW'(1));
        load_ready_w   = (state_q == IDLE) || (last_w && bus.shift_en);
        bus.load_ready = load_ready_w;
        bus.serial_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        bus.ser_valid  = (state_q == SHIFT);
        bus.last_bit   = last_w;
        bus.done       = done_q;
        state_dbg_o    = state_q;
        cnt_dbg_o      = cnt_q;
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Runs an MSB-first and an LSB-first instance in lockstep on identical
// stimulus against a bit-queue scoreboard of {last, lsb_bit, msb_bit}.
module tb_piso_shift_reg;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  piso_shift_reg_if #(.WIDTH(WIDTH)) bus_m ();
  piso_shift_reg_if #(.WIDTH(WIDTH)) bus_l ();
  logic          st_m, st_l;
  logic [CW-1:0] cnt_m, cnt_l;

  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bus_m.slave), .state_dbg_o(st_m), .cnt_dbg_o(cnt_m)
  );
  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l.slave), .state_dbg_o(st_l), .cnt_dbg_o(cnt_l)
  );

  // ---------------- scoreboard state ----------------
  logic [2:0] exp_q[$];
  logic       done_exp;
  logic       accepted;
  int         n_checks;
  int         n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic lv, input logic [WIDTH-1:0] d, input logic se);
    bus_m.load_valid = lv;
    bus_l.load_valid = lv;
    bus_m.data_in    = d;
    bus_l.data_in    = d;
    bus_m.shift_en   = se;
    bus_l.shift_en   = se;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = 0; i < WIDTH; i++)
      exp_q.push_back({(i == WIDTH - 1), d[i], d[WIDTH-1-i]});
  endtask

  task automatic check_reset_values();
    check("rst_m_sout",  32'(bus_m.serial_out), 32'd0);
    check("rst_l_sout",  32'(bus_l.serial_out), 32'd0);
    check("rst_m_valid", 32'(bus_m.ser_valid),  32'd0);
    check("rst_l_valid", 32'(bus_l.ser_valid),  32'd0);
    check("rst_m_last",  32'(bus_m.last_bit),   32'd0);
    check("rst_l_last",  32'(bus_l.last_bit),   32'd0);
    check("rst_m_done",  32'(bus_m.done),       32'd0);
    check("rst_l_done",  32'(bus_l.done),       32'd0);
    check("rst_m_ready", 32'(bus_m.load_ready), 32'd1);
    check("rst_l_ready", 32'(bus_l.load_ready), 32'd1);
    check("rst_m_state", 32'(st_m),  32'd0);
    check("rst_m_cnt",   32'(cnt_m), 32'd0);
    check("rst_l_cnt",   32'(cnt_l), 32'd0);
  endtask

  // One clock: drive at negedge, compare before the rising edge, update model after it.
  task automatic step(input logic lv, input logic [WIDTH-1:0] d, input logic se);
    logic       busy;
    logic [2:0] h;
    logic       rdy_exp;
    drive(lv, d, se);
    #1;
    busy    = (exp_q.size() != 0);
    h       = busy ? exp_q[0] : 3'b000;
    rdy_exp = !busy || (h[2] && se);
    check("m_valid", 32'(bus_m.ser_valid),  32'(busy));
    check("l_valid", 32'(bus_l.ser_valid),  32'(busy));
    check("m_sout",  32'(bus_m.serial_out), 32'(h[0]));
    check("l_sout",  32'(bus_l.serial_out), 32'(h[1]));
    check("m_last",  32'(bus_m.last_bit),   32'(h[2]));
    check("l_last",  32'(bus_l.last_bit),   32'(h[2]));
    check("m_done",  32'(bus_m.done),       32'(done_exp));
    check("l_done",  32'(bus_l.done),       32'(done_exp));
    check("m_ready", 32'(bus_m.load_ready), 32'(rdy_exp));
    check("l_ready", 32'(bus_l.load_ready), 32'(rdy_exp));
    check("m_state", 32'(st_m),  32'(busy));
    check("l_state", 32'(st_l),  32'(busy));
    check("m_cnt",   32'(cnt_m), 32'(exp_q.size()));
    check("l_cnt",   32'(cnt_l), 32'(exp_q.size()));
    accepted = lv && rdy_exp;
    @(posedge clk);
    if (busy && se) void'(exp_q.pop_front());
    done_exp = h[2] && se;
    if (accepted) push_word(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic se);
    for (int i = 0; i < n; i++) step(1'b0, '0, se);
  endtask

  task automatic load_word(input logic [WIDTH-1:0] d, input logic se);
    int tries;
    tries = 0;
    do begin
      step(1'b1, d, se);
      tries++;
    end while (!accepted && tries < 40);
    check("load_accept", 32'(accepted), 32'd1);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    done_exp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic             pend;
    logic [WIDTH-1:0] pd;
    int               tries;
    n_checks = 0;
    n_errors = 0;
    done_exp = 1'b0;
    accepted = 1'b0;
    rst_n    = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    idle(2, 1'b1);                      // shift_en in IDLE does nothing
    load_word(8'hA5, 1'b1); idle(9, 1'b1);
    load_word(8'h01, 1'b1); idle(9, 1'b1);

    load_word(8'hC3, 1'b1);             // stall after three bits
    idle(3, 1'b1); idle(5, 1'b0); idle(6, 1'b1);

    load_word(8'hFF, 1'b1);             // back-to-back, second accept on last bit
    tries = 0;
    do begin
      step(1'b1, 8'h00, 1'b1);
      tries++;
    end while (!accepted && tries < 40);
    check("b2b_accept_cycle", 32'(tries), 32'd8);
    idle(9, 1'b1);

    load_word(8'h0F, 1'b1);             // busy load is ignored
    idle(2, 1'b1);
    step(1'b1, 8'hF0, 1'b1);
    check("busy_ignored", 32'(accepted), 32'd0);
    idle(7, 1'b1);

    load_word(8'hAA, 1'b1);             // reset mid-word
    idle(4, 1'b1);
    async_reset();
    idle(2, 1'b1);
    load_word(8'h81, 1'b1); idle(9, 1'b1);

    pend = 1'b0;
    pd   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        pd   = WIDTH'($urandom_range(0, 255));
      end
      step(pend, pend ? pd : '0, ($urandom_range(0, 3) != 0));
      if (accepted) pend = 1'b0;
    end
    idle(20, 1'b1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
